cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1: level enable; high permits fetching new instructions.
REQ-004 SHALL have port instr_type, input, 2: decoder class; 0 R-type, 1 I-type, 2 load/store, 3 jump.
REQ-005 SHALL have port load_store, input, 1: decoder flag; 0 load, 1 store.
REQ-006 SHALL have port branch, input, 2: decoder flag; 0 none, 1 relative branch, 2 jump, 3 reserved.
REQ-007 SHALL have port pc_change, input, 15: decoder relative PC offset, two's complement.
REQ-008 SHALL have port jump_target, input, 15: absolute target read from the register file.
REQ-009 SHALL have port mem_ready, input, 1: memory completes the current request this cycle.
REQ-010 SHALL have port pc, output, 15: current program counter.
REQ-011 SHALL have port mem_req, output, 1: memory request is active.
REQ-012 SHALL have port mem_we, output, 1: memory write strobe.
REQ-013 SHALL have port mem_addr_sel, output, 1: memory address source; 0 pc, 1 datapath address.
REQ-014 SHALL have port ir_load, output, 1: instruction register capture strobe.
REQ-015 SHALL have port rf_we, output, 1: register file write enable.
REQ-016 SHALL have port state, output, 3: current FSM state encoding.
REQ-017 SHALL have port instr_count, output, 16: count of retired instructions, wrapping.

Function
REQ-018 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; encodings 6 and 7 SHALL go to IDLE on the next cycle.
REQ-019 IDLE: all strobes SHALL be 0; when run=1, next state SHALL be FETCH.
REQ-020 FETCH: mem_req SHALL be 1 and mem_addr_sel SHALL be 0; the FSM SHALL hold until mem_ready=1, then assert ir_load in that same cycle and go to DECODE.
REQ-021 DECODE: one cycle with no strobes, then go to EXEC.
REQ-022 EXEC: instr_type 0 or 1 SHALL go to WB; instr_type 2 SHALL go to MEM; instr_type 3 SHALL retire (see REQ-025).
REQ-023 MEM: mem_req SHALL be 1, mem_addr_sel SHALL be 1 and mem_we SHALL equal load_store; the FSM SHALL hold until mem_ready=1; a load SHALL then go to WB and a store SHALL retire.
REQ-024 WB: rf_we SHALL be 1 for exactly one cycle, then the instruction SHALL retire.
REQ-025 Retire cycle: pc SHALL be updated to jump_target when branch=2, otherwise to pc+pc_change modulo 2^15; branch=3 SHALL be treated as pc+1. instr_count SHALL increment and wrap from 0xFFFF to 0. Next state SHALL be FETCH if run=1, otherwise IDLE.
REQ-026 Decoder inputs SHALL be sampled only in EXEC, MEM and the retire cycle; they are stable because the instruction register is held.
REQ-027 Latency SHALL be FETCH(1+wait)+DECODE+EXEC for a jump, +WB for R/I-type, +MEM(1+wait) for a store, and +MEM+WB for a load; the minimum R-type instruction SHALL take 4 cycles.
REQ-028 Dropping run mid-instruction SHALL NOT abort the instruction; it SHALL complete and retire, then go to IDLE.
REQ-029 mem_we SHALL never be 1 while mem_req=0; ir_load and rf_we SHALL never be 1 in the same cycle.

Reset
REQ-030 While reset=1, regardless of clk, state SHALL be IDLE, pc and instr_count SHALL be 0, and all strobes SHALL be 0.
REQ-031 A reset asserted mid-fetch or mid-memory-access SHALL drop mem_req immediately, and the instruction SHALL NOT retire.

Configuration
REQ-032 With macro CPU_SEQ_SINGLE_STEP_EN defined, a 1-bit input step SHALL exist; every retire SHALL go to IDLE, and IDLE->FETCH SHALL require run=1 and step=1 in the same cycle.
REQ-033 Without CPU_SEQ_SINGLE_STEP_EN, the step port SHALL be absent and behaviour SHALL be per REQ-019/REQ-025.

Structure
REQ-034 Package cpu_seq_pkg SHALL hold the state encodings, instr_type codes, branch codes, and the PC width constant (15).
REQ-035 Sub-module pc_unit SHALL hold the pc register and next-pc mux/adder, with a load strobe supplied by the FSM.

Verification
REQ-036 Bench SHALL check reset followed by run=1 with an R-type instruction and mem_ready tied to 1: sequence FETCH,DECODE,EXEC,WB; pc=1 and instr_count=1 after 4 cycles.
REQ-037 Bench SHALL check a load with mem_ready delayed 3 cycles in MEM: mem_req=1, mem_addr_sel=1 and mem_we=0 for 4 cycles, then one rf_we pulse, then retire.
REQ-038 Bench SHALL check pc=0x0010 with branch=1 and pc_change=0x7FFE (-2): pc becomes 0x000E; pc=0 with pc_change=0x7FFF: pc becomes 0x7FFF (wrap).
REQ-039 Bench SHALL check a store: mem_we=1 only in MEM and no rf_we; then a jump with branch=2 and jump_target=0x1234: pc becomes 0x1234.
REQ-040 Bench SHALL check run dropped in DECODE: the instruction retires and the FSM rests in IDLE; reset asserted during a FETCH wait: mem_req goes to 0 asynchronously and pc stays 0.
REQ-041 Bench SHALL check, with CPU_SEQ_SINGLE_STEP_EN defined, run=1 and step=0: the FSM stays in IDLE; one step pulse executes exactly one instruction.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU sequencer: FSM states, decoder classes and branch codes.
// Used by cpu_sequencer and pc_unit.
package cpu_seq_pkg;

  localparam int PC_W  = 15;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    IT_R    = 2'd0,
    IT_I    = 2'd1,
    IT_LS   = 2'd2,
    IT_JUMP = 2'd3
  } instr_type_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_REL  = 2'd1,
    BR_JUMP = 2'd2,
    BR_RSVD = 2'd3
  } branch_e;

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter register with next-pc selection (relative add, absolute jump, +1).
// The pc only moves when the sequencer pulses load on an instruction's retire cycle.
module pc_unit
  import cpu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [1:0]      branch,
  input  logic [PC_W-1:0] pc_change,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      case (branch_e'(branch))
        BR_JUMP: pc_d = jump_target;
        BR_RSVD: pc_d = pc_q + PC_W'(1);
        default: pc_d = pc_q + pc_change;  // wraps modulo 2^PC_W
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with retire counting.
// Define CPU_SEQ_SINGLE_STEP_EN to add a step input; each retire then parks in IDLE.
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [1:0]       instr_type,
  input  logic             load_store,
  input  logic [1:0]       branch,
  input  logic [PC_W-1:0]  pc_change,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_addr_sel_q, mem_addr_sel_d;
  logic             rf_we_q, rf_we_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;
  logic             start_ok;
  logic             continue_ok;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign start_ok    = run & step;
  assign continue_ok = 1'b0;
`else
  assign start_ok    = run;
  assign continue_ok = run;
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (instr_type_e'(instr_type))
          IT_R, IT_I: state_d = ST_WB;
          IT_LS:      state_d = ST_MEM;
          default:    retire  = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (load_store) retire  = 1'b1;
          else            state_d = ST_WB;
        end
      end
      ST_WB:     retire  = 1'b1;
      default:   state_d = ST_IDLE;  // unused encodings recover to IDLE
    endcase
    if (retire) state_d = continue_ok ? ST_FETCH : ST_IDLE;

    // Strobes are registered from the next state so they line up with state_q.
    mem_req_d      = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_addr_sel_d = (state_d == ST_MEM);
    mem_we_d       = (state_d == ST_MEM) && load_store;
    rf_we_d        = (state_d == ST_WB);
    instr_count_d  = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      mem_req_q      <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      mem_we_q       <= 1'b0;
      rf_we_q        <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      mem_we_q       <= mem_we_d;
      rf_we_q        <= rf_we_d;
      instr_count_q  <= instr_count_d;
    end
  end

  pc_unit u_pc_unit (
    .clk         (clk),
    .rst         (reset),
    .load        (retire),
    .branch      (branch),
    .pc_change   (pc_change),
    .jump_target (jump_target),
    .pc          (pc)
  );

  // Instruction capture must coincide with the memory handshake, so it stays combinational.
  assign ir_load      = (state_q == ST_FETCH) && mem_ready;
  assign mem_req      = mem_req_q;
  assign mem_addr_sel = mem_addr_sel_q;
  assign mem_we       = mem_we_q;
  assign rf_we        = rf_we_q;
  assign state        = state_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, corner sequences, random instructions.
// Define CPU_SEQ_SINGLE_STEP_EN to also exercise the single-step mode.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  typedef struct {
    logic [1:0]  it;
    logic        ls;
    logic [1:0]  br;
    logic [14:0] pcc;
    logic [14:0] jt;
    int          fw;
    int          mw;
    int          exp_cyc;
    logic [14:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [1:0]  instr_type;
  logic        load_store;
  logic [1:0]  branch;
  logic [14:0] pc_change;
  logic [14:0] jump_target;
  logic        mem_ready;
  logic [14:0] pc;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_load;
  logic        rf_we;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  logic [14:0] m_pc;
  logic [15:0] m_cnt;
  vec_t        vecs[8];

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step         (step),
`endif
    .instr_type   (instr_type),
    .load_store   (load_store),
    .branch       (branch),
    .pc_change    (pc_change),
    .jump_target  (jump_target),
    .mem_ready    (mem_ready),
    .pc           (pc),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .rf_we        (rf_we),
    .state        (state),
    .instr_count  (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from first FETCH to retire, straight from the latency rules.
  function automatic int lat(vec_t v);
    int n;
    n = v.fw + 3;
    if (v.it == 2'd0 || v.it == 2'd1) n += 1;
    else if (v.it == 2'd2) n += v.mw + 1 + (v.ls ? 0 : 1);
    return n;
  endfunction

  function automatic logic [14:0] npc(logic [14:0] p, vec_t v);
    case (v.br)
      2'd2:    return v.jt;
      2'd3:    return p + 15'd1;
      default: return p + v.pcc;
    endcase
  endfunction

  // Called just after a negedge; returns just after the negedge following retire.
  task automatic run_instr(input vec_t v, input bit drop, output int cyc, output int rf_n,
                           output int we_n, output int dsel_n, output int ir_n,
                           output logic [23:0] seq);
    logic [15:0] cnt0;
    int          wcnt;
    logic [2:0]  prev;
    bit          done;
    instr_type  = v.it;
    load_store  = v.ls;
    branch      = v.br;
    pc_change   = v.pcc;
    jump_target = v.jt;
    cnt0 = instr_count;
    cyc = 0; rf_n = 0; we_n = 0; dsel_n = 0; ir_n = 0; seq = '0;
    wcnt = 0; prev = 3'd7; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (state != prev) wcnt = 0;
      prev = state;
      if (state == 3'd1)      mem_ready = (wcnt == v.fw);
      else if (state == 3'd4) mem_ready = (wcnt == v.mw);
      else                    mem_ready = 1'($urandom_range(0, 1));
      wcnt++;
      if (drop && state == 3'd2) run = 1'b0;
      #1;
      if (state != 3'd0) begin
        cyc++;
        seq = {seq[20:0], state};
      end
      if (rf_we) rf_n++;
      if (mem_we) we_n++;
      if (mem_req && mem_addr_sel) dsel_n++;
      if (ir_load) ir_n++;
      chk("we_without_req", 32'(mem_we & ~mem_req), 32'd0);
      chk("irload_and_rfwe", 32'(ir_load & rf_we), 32'd0);
      if (state == 3'd0)
        chk("idle_strobes", 32'({mem_req, mem_we, mem_addr_sel, ir_load, rf_we}), 32'd0);
      @(negedge clk);
      if (instr_count != cnt0) done = 1'b1;
    end
    chk("retire_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_instr(input string tag, input vec_t v, input int cyc, input int rf_n,
                             input int we_n, input int dsel_n, input int ir_n);
    bit is_store;
    is_store = (v.it == 2'd2) && v.ls;
    chk({tag, "_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    chk({tag, "_pc"}, 32'(pc), 32'(v.exp_pc));
    chk({tag, "_count"}, 32'(instr_count), 32'(m_cnt));
    chk({tag, "_rf_we"}, 32'(rf_n), (v.it == 2'd3 || is_store) ? 32'd0 : 32'd1);
    chk({tag, "_mem_we"}, 32'(we_n), is_store ? 32'(v.mw + 1) : 32'd0);
    chk({tag, "_data_acc"}, 32'(dsel_n), (v.it == 2'd2) ? 32'(v.mw + 1) : 32'd0);
    chk({tag, "_ir_load"}, 32'(ir_n), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_pc  = '0;
    m_cnt = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, rf_n, we_n, dsel_n, ir_n;
    logic [23:0] seq;
    vec_t        v;

    vecs[0] = '{2'd0, 1'b0, 2'd0, 15'h0001, 15'h0000, 0, 0, 4, 15'h0001};
    vecs[1] = '{2'd2, 1'b0, 2'd0, 15'h0001, 15'h0000, 0, 3, 8, 15'h0002};
    vecs[2] = '{2'd2, 1'b1, 2'd1, 15'h000E, 15'h0000, 1, 0, 5, 15'h0010};
    vecs[3] = '{2'd3, 1'b0, 2'd1, 15'h7FFE, 15'h5555, 0, 0, 3, 15'h000E};
    vecs[4] = '{2'd3, 1'b0, 2'd2, 15'h0003, 15'h1234, 2, 0, 5, 15'h1234};
    vecs[5] = '{2'd1, 1'b0, 2'd3, 15'h0055, 15'h0000, 0, 0, 4, 15'h1235};
    vecs[6] = '{2'd3, 1'b1, 2'd2, 15'h0007, 15'h0000, 0, 0, 3, 15'h0000};
    vecs[7] = '{2'd1, 1'b0, 2'd1, 15'h7FFF, 15'h0000, 0, 0, 4, 15'h7FFF};

    instr_type = 2'd0; load_store = 1'b0; branch = 2'd0;
    pc_change = '0; jump_target = '0; mem_ready = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_strobes", 32'({mem_req, mem_we, mem_addr_sel, ir_load, rf_we}), 32'd0);
    do_reset();

    // Directed table, back-to-back with run held high.
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i], 1'b0, cyc, rf_n, we_n, dsel_n, ir_n, seq);
      m_cnt++;
      m_pc = vecs[i].exp_pc;
      check_instr($sformatf("vec%0d", i), vecs[i], cyc, rf_n, we_n, dsel_n, ir_n);
      $display("vec%0d it=%0d br=%0d cycles=%0d pc=0x%04h count=%0d",
               i, vecs[i].it, vecs[i].br, cyc, pc, instr_count);
      if (i == 0) chk("rtype_state_seq", 32'(seq[11:0]), 32'({3'd1, 3'd2, 3'd3, 3'd5}));
    end

    // run dropped in DECODE: instruction completes, FSM then rests in IDLE.
    v = '{2'd0, 1'b0, 2'd0, 15'h0002, 15'h0000, 0, 0, 4, 15'h0001};
    run_instr(v, 1'b1, cyc, rf_n, we_n, dsel_n, ir_n, seq);
    m_cnt++;
    check_instr("drop_run", v, cyc, rf_n, we_n, dsel_n, ir_n);
    chk("drop_run_idle", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    chk("drop_run_stays_idle", 32'(state), 32'd0);
    chk("drop_run_no_extra", 32'(instr_count), 32'(m_cnt));
    $display("drop_run cycles=%0d pc=0x%04h state=%0d", cyc, pc, state);
    m_pc = pc;
    run = 1'b1;

    // Randomised instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.it  = 2'($urandom_range(0, 3));
      v.ls  = 1'($urandom_range(0, 1));
      v.br  = 2'($urandom_range(0, 3));
      v.pcc = 15'($urandom);
      v.jt  = 15'($urandom);
      v.fw  = $urandom_range(0, 3);
      v.mw  = $urandom_range(0, 3);
      v.exp_cyc = lat(v);
      v.exp_pc  = npc(m_pc, v);
      run_instr(v, 1'b0, cyc, rf_n, we_n, dsel_n, ir_n, seq);
      m_cnt++;
      m_pc = v.exp_pc;
      check_instr($sformatf("rnd%0d", i), v, cyc, rf_n, we_n, dsel_n, ir_n);
      $display("rnd%0d it=%0d ls=%0d br=%0d fw=%0d mw=%0d cycles=%0d pc=0x%04h",
               i, v.it, v.ls, v.br, v.fw, v.mw, cyc, pc);
    end

    // Reset in the middle of a FETCH wait.
    do_reset();
    run = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("fetch_wait_state", 32'(state), 32'd1);
    chk("fetch_wait_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("async_rst_no_retire", 32'(instr_count), 32'd0);
    $display("fetch_reset mem_req=%0d pc=0x%04h count=%0d", mem_req, pc, instr_count);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    do_reset();
    step = 1'b0;
    run  = 1'b1;
    repeat (5) @(negedge clk);
    chk("step_hold_idle", 32'(state), 32'd0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    v = '{2'd0, 1'b0, 2'd0, 15'h0001, 15'h0000, 0, 0, 4, 15'h0001};
    run_instr(v, 1'b0, cyc, rf_n, we_n, dsel_n, ir_n, seq);
    m_cnt++;
    check_instr("step", v, cyc, rf_n, we_n, dsel_n, ir_n);
    chk("step_back_idle", 32'(state), 32'd0);
    repeat (4) @(negedge clk);
    chk("step_stays_idle", 32'(state), 32'd0);
    chk("step_one_instr", 32'(instr_count), 32'd1);
    $display("single_step cycles=%0d pc=0x%04h count=%0d", cyc, pc, instr_count);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
